// File: rtl/input_rom_loader.sv
// input_rom_loader
//   Responder side of the puzzle-input ROM read interface. A byte stream
//   (valid/ready, in_last marks the final byte) is captured into on-chip RAM.
//   Once the load completes, rom_addr -> rom_data/rom_valid reads are served
//   with one cycle of latency. It replaces the file-backed simulation ROM on FPGA.
//
//   Optional feature: define LOAD_CHECKSUM_EN to add load_checksum, the
//   mod-2^16 sum of every accepted byte.
//
// Ports
//   clk, rst       clock (rising edge), synchronous active-high reset
//   in_data/in_valid/in_last/in_ready   load stream
//   rom_addr       read address (N_ADDR_BITS+1 bits, MSB set = out of range)
//   rom_data       registered read data, 0 when not valid
//   rom_valid      rom_data is a byte inside the loaded input
//   loaded         load complete, reads are serviced
//   length         number of bytes stored
//   overflow       stream exceeded DEPTH; excess bytes back-pressured
//   load_checksum  (LOAD_CHECKSUM_EN only) sum of accepted bytes
module input_rom_loader #(
    parameter int N_ADDR_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic [N_ADDR_BITS:0]   rom_addr,
    output logic [7:0]             rom_data,
    output logic                   rom_valid,
    output logic                   loaded,
    output logic [N_ADDR_BITS:0]   length,
    output logic                   overflow
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [15:0]            load_checksum
`endif
);

    localparam int DEPTH = 2 ** N_ADDR_BITS;
    localparam logic [N_ADDR_BITS:0] PTR_ONE  = (N_ADDR_BITS + 1)'(1);
    localparam logic [N_ADDR_BITS:0] LAST_IDX = (N_ADDR_BITS + 1)'(DEPTH - 1);
    localparam logic [N_ADDR_BITS:0] FULL_LEN = (N_ADDR_BITS + 1)'(DEPTH);

    typedef enum logic {S_LOAD, S_READY} state_t;

    state_t                 state;
    logic [N_ADDR_BITS:0]   wr_ptr;
    logic                   wr_en;
    logic                   rd_hit;
    logic [7:0]             mem [DEPTH];

    // in_ready must already be low in the reset cycle itself, so it is
    // decoded from the state rather than registered.
    assign in_ready = (state == S_LOAD) && !rst;
    assign wr_en    = in_valid && in_ready;

    // rd_hit uses the pre-edge loaded/length, so the LOAD->READY edge
    // still returns an invalid read.
    assign rd_hit   = loaded && (rom_addr < length);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_LOAD;
            wr_ptr   <= '0;
            loaded   <= 1'b0;
            length   <= '0;
            overflow <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            load_checksum <= 16'h0000;
`endif
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
`ifdef LOAD_CHECKSUM_EN
            load_checksum <= load_checksum + {8'h00, in_data};
`endif
            if (in_last) begin
                state  <= S_READY;
                loaded <= 1'b1;
                length <= wr_ptr + PTR_ONE;
            end else if (wr_ptr == LAST_IDX) begin
                // RAM full without a last byte: stop accepting and flag it.
                state    <= S_READY;
                loaded   <= 1'b1;
                length   <= FULL_LEN;
                overflow <= 1'b1;
            end
        end
    end

    // Write port; RAM is not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[N_ADDR_BITS-1:0]] <= in_data;
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_valid <= 1'b0;
            rom_data  <= 8'h00;
        end else begin
            rom_valid <= rd_hit;
            rom_data  <= rd_hit ? mem[rom_addr[N_ADDR_BITS-1:0]] : 8'h00;
        end
    end

endmodule

// File: tb/tb_input_rom_loader.sv
module tb_input_rom_loader;
    localparam int N     = 3;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [N:0]   rom_addr = '0;
    logic [7:0]   rom_data;
    logic         rom_valid;
    logic         loaded;
    logic [N:0]   length;
    logic         overflow;
`ifdef LOAD_CHECKSUM_EN
    logic [15:0]  load_checksum;
`endif

    always #5 clk = ~clk;

    input_rom_loader #(.N_ADDR_BITS(N)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_valid(rom_valid),
        .loaded(loaded), .length(length), .overflow(overflow)
`ifdef LOAD_CHECKSUM_EN
        , .load_checksum(load_checksum)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the bytes the stream delivered, plus load status.
    logic [7:0] m_mem [DEPTH];
    int         m_wp, m_len, m_ck;
    bit         m_loaded, m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit vin);
        rst = 1'b1; in_valid = vin; in_data = 8'($urandom); in_last = 1'b0; rom_addr = '0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        m_wp = 0; m_len = 0; m_ck = 0; m_loaded = 0; m_ovf = 0;
        chk("rst_rom_valid", rom_valid, 0);
        chk("rst_rom_data", rom_data, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_length", length, 0);
        chk("rst_overflow", overflow, 0);
`ifdef LOAD_CHECKSUM_EN
        chk("rst_cksum", load_checksum, 0);
`endif
        rst = 1'b0; in_valid = 1'b0;
    endtask

    // One clock: drive inputs, check ready before the edge, check outputs after.
    task automatic cycle(input bit v, input logic [7:0] d, input bit l, input int a);
        bit exp_v;
        int exp_d;
        in_valid = v; in_data = d; in_last = l; rom_addr = (N + 1)'(a);
        @(negedge clk);
        chk("in_ready", in_ready, !m_loaded);
        exp_v = m_loaded && (a < m_len);
        exp_d = exp_v ? int'(m_mem[a]) : 0;
        if (v && !m_loaded) begin
            m_mem[m_wp] = d;
            m_ck = (m_ck + d) % 65536;
            if (l) begin
                m_loaded = 1; m_len = m_wp + 1;
            end else if (m_wp == DEPTH - 1) begin
                m_loaded = 1; m_len = DEPTH; m_ovf = 1;
            end
            m_wp++;
        end
        @(posedge clk); #1;
        chk("rom_valid", rom_valid, exp_v);
        chk("rom_data", rom_data, exp_d);
        chk("loaded", loaded, m_loaded);
        chk("length", length, m_len);
        chk("overflow", overflow, m_ovf);
`ifdef LOAD_CHECKSUM_EN
        chk("cksum", load_checksum, m_ck);
`endif
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        logic [7:0] s1 [4];
        s1[0] = 8'h4C; s1[1] = 8'h36; s1[2] = 8'h38; s1[3] = 8'h0A;

        // "L68\n", reading addr 0 throughout the load and on the READY edge.
        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, s1[i], i == 3, 0);
            chk("t1_load_valid", rom_valid, 0);
        end
        chk("t1_length", length, 4);
        for (int a = 0; a < 5; a++) begin
            cycle(0, 8'h00, 0, a);
            chk("t1_data", rom_data, (a < 4) ? int'(s1[a]) : 0);
            chk("t1_valid", rom_valid, (a < 4) ? 1 : 0);
        end

        // 10 bytes without last: 8 stored, overflow, rest back-pressured.
        do_reset(0);
        for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), 0, 0);
        chk("t3_overflow", overflow, 1);
        chk("t3_length", length, 8);
        for (int a = 0; a < 16; a++) cycle($urandom_range(0, 1) == 1, 8'($urandom), 0, a);
        cycle(0, 8'h00, 0, 8);
        chk("t3_msb_addr", rom_valid, 0);

        // Exactly DEPTH bytes with last on the final one.
        do_reset(0);
        for (int i = 0; i < 8; i++) cycle(1, 8'($urandom), i == 7, 0);
        chk("t4_overflow", overflow, 0);
        chk("t4_length", length, 8);
        cycle(0, 8'h00, 0, 7);
        chk("t4_addr7", rom_valid, 1);

        // Reset mid-load, then "AB".
        do_reset(0);
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 0, 0);
        do_reset(1);
        cycle(1, 8'h41, 0, 0);
        cycle(1, 8'h42, 1, 0);
        chk("t5_length", length, 2);
        for (int a = 0; a < 4; a++) cycle(0, 8'h00, 0, a);
        cycle(0, 8'h00, 0, 1);
        chk("t5_B", rom_data, 8'h42);

        // in_valid toggled 1-0-1.
        do_reset(0);
        cycle(1, 8'h5A, 0, 0);
        cycle(0, 8'hEE, 1, 0);
        cycle(1, 8'hA5, 1, 0);
        cycle(0, 8'h00, 0, 1);
        chk("t6_second", rom_data, 8'hA5);
        chk("t6_length", length, 2);

        // Randomized rounds: gaps, random lengths, random reads, optional mid-load reset.
        for (int r = 0; r < 25; r++) begin
            int n, got;
            do_reset($urandom_range(0, 1) == 1);
            n = $urandom_range(1, 12);
            got = 0;
            for (int c = 0; c < 40 && !m_loaded; c++) begin
                bit v, was;
                if (c == 3 && $urandom_range(0, 5) == 0) begin
                    do_reset(1);
                    got = 0;
                end
                v = $urandom_range(0, 2) != 0;
                was = m_loaded;
                cycle(v, 8'($urandom), got == n - 1, $urandom_range(0, 15));
                if (v && !was) got++;
            end
            for (int k = 0; k < 12; k++)
                cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 15));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
